// File: rtl/prefetch_queue.sv
// Instruction-byte prefetch queue: circular buffer with multi-entry head peek,
// variable-length pull, flush on redirect and registered error pulses.
module prefetch_queue #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PEEK   = 3
) (
  input  logic                       clk,
  input  logic                       queue_reset,
  input  logic                       queue_flush,
  input  logic                       queue_push,
  input  logic [DATA_W-1:0]          queue_in,
  input  logic [1:0]                 queue_pull_len,
  output logic [PEEK*DATA_W-1:0]     queue_out,
  output logic [PEEK-1:0]            queue_valid,
  output logic [$clog2(DEPTH):0]     queue_count,
  output logic                       full,
  output logic                       empty,
  output logic                       push_drop,
  output logic                       pull_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_drop_q, push_drop_d;
  logic              pull_err_q, pull_err_d;
  logic              mem_we;
  logic              push_ok;
  logic              pull_ok;
  logic              pull_req;
  logic [CNT_W-1:0]  pull_len;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign queue_count = count_q;
  assign push_drop   = push_drop_q;
  assign pull_err    = pull_err_q;

  // Next-state: flush discards everything and suppresses both error pulses.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    push_drop_d = 1'b0;
    pull_err_d  = 1'b0;
    mem_we      = 1'b0;
    push_ok     = 1'b0;
    pull_ok     = 1'b0;
    pull_req    = (queue_pull_len != 2'd0);
    pull_len    = CNT_W'(queue_pull_len);
    if (queue_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      pull_ok     = pull_req && (32'(queue_pull_len) <= PEEK) && (pull_len <= count_q);
      push_ok     = queue_push && !full;
      push_drop_d = queue_push && full;
      pull_err_d  = pull_req && !pull_ok;
      mem_we      = push_ok;
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pull_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(queue_pull_len);
      end
      count_d = count_q + CNT_W'(push_ok) - (pull_ok ? pull_len : CNT_W'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (queue_reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      push_drop_q <= 1'b0;
      pull_err_q  <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      push_drop_q <= push_drop_d;
      pull_err_q  <= pull_err_d;
    end
  end

  // Storage is never cleared; stale entries are masked by the valid logic below.
  always_ff @(posedge clk) begin
    if (mem_we && !queue_reset) begin
      mem_q[wr_ptr_q] <= queue_in;
    end
  end

  always_comb begin
    queue_out   = '0;
    queue_valid = '0;
    for (int unsigned i = 0; i < PEEK; i++) begin
      if (32'(count_q) > i) begin
        queue_valid[i]                = 1'b1;
        queue_out[i*DATA_W +: DATA_W] = mem_q[rd_ptr_q + PTR_W'(i)];
      end
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: directed scenarios plus randomized
// push/pull/flush/reset traffic compared against a queue-based reference model.
module tb_prefetch_queue;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PEEK   = 3;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic                   clk = 1'b0;
  logic                   queue_reset;
  logic                   queue_flush;
  logic                   queue_push;
  logic [DATA_W-1:0]      queue_in;
  logic [1:0]             queue_pull_len;
  logic [PEEK*DATA_W-1:0] queue_out;
  logic [PEEK-1:0]        queue_valid;
  logic [CNT_W-1:0]       queue_count;
  logic                   full, empty, push_drop, pull_err;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mq [$];
  logic              exp_drop = 1'b0;
  logic              exp_err  = 1'b0;

  prefetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PEEK(PEEK)) dut (
    .clk           (clk),
    .queue_reset   (queue_reset),
    .queue_flush   (queue_flush),
    .queue_push    (queue_push),
    .queue_in      (queue_in),
    .queue_pull_len(queue_pull_len),
    .queue_out     (queue_out),
    .queue_valid   (queue_valid),
    .queue_count   (queue_count),
    .full          (full),
    .empty         (empty),
    .push_drop     (push_drop),
    .pull_err      (pull_err)
  );

  always #5 clk = ~clk;

  // Reference model step applied on the pre-edge state, then one clock.
  task automatic cyc(input logic push, input logic [DATA_W-1:0] din,
                     input logic [1:0] len, input logic flush, input logic rst);
    int unsigned pre;
    logic err, drop;
    queue_push     = push;
    queue_in       = din;
    queue_pull_len = len;
    queue_flush    = flush;
    queue_reset    = rst;
    pre = mq.size();
    if (rst || flush) begin
      mq.delete();
      exp_drop = 1'b0;
      exp_err  = 1'b0;
    end else begin
      err  = (len != 2'd0) && ((int'(len) > int'(PEEK)) || (int'(len) > int'(pre)));
      drop = push && (pre == DEPTH);
      if (len != 2'd0 && !err) repeat (int'(len)) void'(mq.pop_front());
      if (push && !drop) mq.push_back(din);
      exp_drop = drop;
      exp_err  = err;
    end
    @(posedge clk);
    #1;
    queue_push     = 1'b0;
    queue_in       = '0;
    queue_pull_len = 2'd0;
    queue_flush    = 1'b0;
    queue_reset    = 1'b0;
  endtask

  function automatic logic [PEEK*DATA_W-1:0] model_out();
    logic [PEEK*DATA_W-1:0] v = '0;
    for (int i = 0; i < int'(PEEK); i++)
      if (i < mq.size()) v[i*DATA_W +: DATA_W] = mq[i];
    return v;
  endfunction

  function automatic logic [PEEK-1:0] model_valid();
    logic [PEEK-1:0] v = '0;
    for (int i = 0; i < int'(PEEK); i++) v[i] = (i < mq.size());
    return v;
  endfunction

  task automatic test_reset();
    cyc(1'b1, 8'h33, 2'd1, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    checks++; if (queue_count !== 5'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", queue_count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags: got empty=%b full=%b expected 1/0", empty, full); end
    checks++; if (queue_valid !== 3'b000 || queue_out !== 24'h0) begin failures++; $display("FAIL reset_peek: got valid=%b out=%h expected 000/000000", queue_valid, queue_out); end
    checks++; if (push_drop !== 1'b0 || pull_err !== 1'b0) begin failures++; $display("FAIL reset_pulses: got drop=%b err=%b expected 0/0", push_drop, pull_err); end
  endtask

  task automatic test_basic();
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    cyc(1'b1, 8'hA9, 2'd0, 1'b0, 1'b0);
    checks++; if (queue_out[7:0] !== 8'hA9 || queue_valid !== 3'b001) begin failures++; $display("FAIL basic_first: got out=%h valid=%b expected ..a9/001", queue_out, queue_valid); end
    cyc(1'b1, 8'h10, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 8'h8D, 2'd0, 1'b0, 1'b0);
    checks++; if (queue_count !== 5'd3) begin failures++; $display("FAIL basic_count: got %0d expected 3", queue_count); end
    checks++; if (queue_out !== 24'h8D10A9 || queue_valid !== 3'b111) begin failures++; $display("FAIL basic_peek: got out=%h valid=%b expected 8d10a9/111", queue_out, queue_valid); end
    cyc(1'b0, 8'h00, 2'd3, 1'b0, 1'b0);
    checks++; if (empty !== 1'b1 || queue_valid !== 3'b000 || pull_err !== 1'b0) begin failures++; $display("FAIL basic_pull3: got empty=%b valid=%b err=%b expected 1/000/0", empty, queue_valid, pull_err); end
  endtask

  task automatic test_full();
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 2'd0, 1'b0, 1'b0);
    checks++; if (full !== 1'b1 || queue_count !== 5'd16) begin failures++; $display("FAIL full_flag: got full=%b count=%0d expected 1/16", full, queue_count); end
    cyc(1'b1, 8'hFF, 2'd0, 1'b0, 1'b0);
    checks++; if (push_drop !== 1'b1) begin failures++; $display("FAIL full_drop: got %b expected 1", push_drop); end
    checks++; if (queue_count !== 5'd16 || queue_out !== 24'h020100) begin failures++; $display("FAIL full_hold: got count=%0d out=%h expected 16/020100", queue_count, queue_out); end
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    checks++; if (push_drop !== 1'b0) begin failures++; $display("FAIL full_drop_clear: got %b expected 0", push_drop); end
  endtask

  task automatic test_wrap();
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 2'd3, 1'b0, 1'b0);
    checks++; if (queue_count !== 5'd1 || queue_out !== 24'h00000F) begin failures++; $display("FAIL wrap_drain: got count=%0d out=%h expected 1/00000f", queue_count, queue_out); end
    for (int i = 0; i < 15; i++) cyc(1'b1, 8'(8'h20 + i), 2'd0, 1'b0, 1'b0);
    checks++; if (queue_count !== 5'd16 || full !== 1'b1) begin failures++; $display("FAIL wrap_refill: got count=%0d full=%b expected 16/1", queue_count, full); end
    checks++; if (queue_out !== 24'h21200F) begin failures++; $display("FAIL wrap_head: got %h expected 21200f", queue_out); end
    cyc(1'b0, 8'h00, 2'd3, 1'b0, 1'b0);
    checks++; if (queue_out !== 24'h242322) begin failures++; $display("FAIL wrap_next: got %h expected 242322", queue_out); end
  endtask

  task automatic test_pull_err();
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    cyc(1'b1, 8'h11, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 2'd3, 1'b0, 1'b0);
    checks++; if (pull_err !== 1'b1) begin failures++; $display("FAIL perr_pulse: got %b expected 1", pull_err); end
    checks++; if (queue_count !== 5'd2 || queue_out !== 24'h002211 || queue_valid !== 3'b011) begin failures++; $display("FAIL perr_hold: got count=%0d out=%h valid=%b expected 2/002211/011", queue_count, queue_out, queue_valid); end
    cyc(1'b1, 8'h55, 2'd3, 1'b0, 1'b0);
    checks++; if (pull_err !== 1'b1 || queue_count !== 5'd3 || queue_out !== 24'h552211) begin failures++; $display("FAIL perr_push: got err=%b count=%0d out=%h expected 1/3/552211", pull_err, queue_count, queue_out); end
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    checks++; if (pull_err !== 1'b0) begin failures++; $display("FAIL perr_clear: got %b expected 0", pull_err); end
  endtask

  task automatic test_back_to_back();
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 2'd2, 1'b0, 1'b0);
    checks++; if (queue_count !== 5'd4 || queue_out !== 24'h444342) begin failures++; $display("FAIL b2b_pushpull: got count=%0d out=%h expected 4/444342", queue_count, queue_out); end
    cyc(1'b1, 8'h99, 2'd3, 1'b1, 1'b0);
    checks++; if (queue_count !== 5'd0 || empty !== 1'b1 || push_drop !== 1'b0 || pull_err !== 1'b0) begin failures++; $display("FAIL b2b_flush: got count=%0d empty=%b drop=%b err=%b expected 0/1/0/0", queue_count, empty, push_drop, pull_err); end
    cyc(1'b1, 8'hAB, 2'd0, 1'b0, 1'b0);
    checks++; if (queue_out !== 24'h0000AB || queue_count !== 5'd1) begin failures++; $display("FAIL b2b_after_flush: got out=%h count=%0d expected 0000ab/1", queue_out, queue_count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h60 + i), 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 2'd3, 1'b1, 1'b1);
    checks++; if (queue_count !== 5'd0 || push_drop !== 1'b0 || pull_err !== 1'b0 || queue_out !== 24'h0) begin failures++; $display("FAIL rstmid: got count=%0d drop=%b err=%b out=%h expected 0/0/0/000000", queue_count, push_drop, pull_err, queue_out); end
  endtask

  task automatic test_random();
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(0, 99) < 60), 8'($urandom), 2'($urandom),
          ($urandom_range(0, 99) < 2), ($urandom_range(0, 199) == 0));
      checks++; if (queue_count !== CNT_W'(mq.size())) begin failures++; $display("FAIL rand_count @%0d: got %0d expected %0d", n, queue_count, mq.size()); end
      checks++; if (queue_out !== model_out()) begin failures++; $display("FAIL rand_out @%0d: got %h expected %h", n, queue_out, model_out()); end
      checks++; if (queue_valid !== model_valid()) begin failures++; $display("FAIL rand_valid @%0d: got %b expected %b", n, queue_valid, model_valid()); end
      checks++; if (full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin failures++; $display("FAIL rand_flags @%0d: got full=%b empty=%b size=%0d", n, full, empty, mq.size()); end
      checks++; if (push_drop !== exp_drop || pull_err !== exp_err) begin failures++; $display("FAIL rand_pulses @%0d: got drop=%b err=%b expected %b/%b", n, push_drop, pull_err, exp_drop, exp_err); end
    end
  endtask

  initial begin
    queue_reset    = 1'b1;
    queue_flush    = 1'b0;
    queue_push     = 1'b0;
    queue_in       = '0;
    queue_pull_len = 2'd0;
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_pull_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
